alu_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter/rotator for the RV32IM execute stage and the successor to the single-cycle combinational shift unit. Adds XLEN and pipeline-depth parameters, rotate modes, a valid/ready handshake with full backpressure, and a flush for trap/interrupt redirection. Sits beside the adder in the ALU. Results return in order with a caller-supplied tag for writeback routing.

---
 rtl/alu_pkg.sv | 15 +
 rtl/shift_level.sv | 30 +++
 rtl/alu_shift_pipe.sv | 120 ++++++++++++
 tb/tb_alu_shift_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes and default widths.
package alu_pkg;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SRL = 3'b001,
    SHIFT_SRA = 3'b010,
    SHIFT_ROL = 3'b011,
    SHIFT_ROR = 3'b100
  } shift_op_e;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_TAG_W = 5;

endpackage

// File: rtl/shift_level.sv
// One level of the logarithmic shifter: shifts/rotates by 2^LVL when en is set.
module shift_level
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int LVL  = 0
) (
  input  logic [XLEN-1:0] data,
  input  logic            en,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result
);

  localparam int AMT = 1 << LVL;

  always_comb begin
    result = data;
    if (en) begin
      case (op)
        SHIFT_SLL: result = {data[XLEN-AMT-1:0], {AMT{1'b0}}};
        SHIFT_SRL: result = {{AMT{1'b0}}, data[XLEN-1:AMT]};
        SHIFT_SRA: result = {{AMT{data[XLEN-1]}}, data[XLEN-1:AMT]};
        SHIFT_ROL: result = {data[XLEN-AMT-1:0], data[XLEN-1:XLEN-AMT]};
        SHIFT_ROR: result = {data[AMT-1:0], data[XLEN-1:AMT]};
        default:   result = data;
      endcase
    end
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// Elastic pipelined barrel shifter/rotator; stage k's levels sit after register k.
module alu_shift_pipe
  import alu_pkg::*;
#(
  parameter int XLEN   = ALU_XLEN,
  parameter int STAGES = 2,
  parameter int TAG_W  = ALU_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [2:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int L = $clog2(XLEN);

  logic             v_q     [STAGES];
  logic [XLEN-1:0]  d_q     [STAGES];
  logic [L-1:0]     sh_q    [STAGES];
  logic [2:0]       op_q    [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];

  logic             nxt_v   [STAGES];
  logic [XLEN-1:0]  nxt_d   [STAGES];
  logic [L-1:0]     nxt_sh  [STAGES];
  logic [2:0]       nxt_op  [STAGES];
  logic [TAG_W-1:0] nxt_tag [STAGES];

  logic [XLEN-1:0]  lvl_out   [L];
  logic [XLEN-1:0]  stage_out [STAGES];
  logic [STAGES-1:0] adv;

  logic unused_b;
  assign unused_b = ^b_i[XLEN-1:L];

  // Stage k advances unless it and every stage after it are full with the output stalled.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & v_q[k];
      adv[k] = out_ready_i | !full;
    end
  end

  assign in_ready_o  = adv[0];
  assign out_valid_o = v_q[STAGES-1];
  assign result_o    = stage_out[STAGES-1];
  assign tag_o       = tag_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_nxt
    if (k == 0) begin : g_head
      assign nxt_v[k]   = in_valid_i;
      assign nxt_d[k]   = a_i;
      assign nxt_sh[k]  = b_i[L-1:0];
      assign nxt_op[k]  = op_i;
      assign nxt_tag[k] = tag_i;
    end else begin : g_body
      assign nxt_v[k]   = v_q[k-1];
      assign nxt_d[k]   = stage_out[k-1];
      assign nxt_sh[k]  = sh_q[k-1];
      assign nxt_op[k]  = op_q[k-1];
      assign nxt_tag[k] = tag_q[k-1];
    end
  end

  // Levels owned by stage S chain off register S; the last one feeds the next stage.
  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int S = (i * STAGES) / L;
    logic [XLEN-1:0] lin;
    if (i == 0 || (((i - 1) * STAGES) / L) != S) begin : g_first
      assign lin = d_q[S];
    end else begin : g_chain
      assign lin = lvl_out[i-1];
    end
    shift_level #(.XLEN(XLEN), .LVL(i)) u_lvl (
      .data   (lin),
      .en     (sh_q[S][i]),
      .op     (op_q[S]),
      .result (lvl_out[i])
    );
    if (i == L - 1 || (((i + 1) * STAGES) / L) != S) begin : g_last
      assign stage_out[S] = lvl_out[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        d_q[k]   <= '0;
        sh_q[k]  <= '0;
        op_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush_i)     v_q[k] <= 1'b0;
        else if (adv[k]) v_q[k] <= nxt_v[k];
        if (adv[k]) begin
          d_q[k]   <= nxt_d[k];
          sh_q[k]  <= nxt_sh[k];
          op_q[k]  <= nxt_op[k];
          tag_q[k] <= nxt_tag[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Bench for alu_shift_pipe (XLEN=32, STAGES=2) against a plain-arithmetic shift model.
module tb_alu_shift_pipe;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
  } item_t;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]  a, b, result;
  logic [2:0]       op;
  logic [TAG_W-1:0] tag, tag_out;

  int total = 0;
  int bad   = 0;
  item_t exp_q[$];
  item_t got_q[$];

  alu_shift_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .op_i        (op),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ref_shift(logic [XLEN-1:0] x, logic [XLEN-1:0] y,
                                                 logic [2:0] o);
    int sh;
    logic [2*XLEN-1:0] dbl;
    sh  = int'(y[4:0]);
    dbl = {x, x};
    case (o)
      3'd0: return x << sh;
      3'd1: return x >> sh;
      3'd2: return XLEN'($signed(x) >>> sh);
      3'd3: begin dbl = dbl << sh; return dbl[2*XLEN-1:XLEN]; end
      3'd4: begin dbl = dbl >> sh; return dbl[XLEN-1:0]; end
      default: return x;
    endcase
  endfunction

  // Records accepted requests (with model result) and consumed results.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready && !flush) exp_q.push_back('{tag, ref_shift(a, b, op)});
      if (out_valid && out_ready) got_q.push_back('{tag_out, result});
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; a = '0; b = '0; op = '0; tag = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); out_ready = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (tag_out !== '0) begin bad++; $display("FAIL reset_tag got=%h want=0", tag_out); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]      t_op [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [XLEN-1:0] t_a  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001};
    logic [XLEN-1:0] t_b  [4] = '{32'd31, 32'd31, 32'h0000_0021, 32'h0000_0021};
    logic [XLEN-1:0] t_e  [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0003, 32'hC000_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = t_op[i]; a = t_a[i]; b = t_b[i]; tag = TAG_W'(i + 3);
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_early_valid[%0d] got=%b want=0", i, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || result !== t_e[i] || tag_out !== TAG_W'(i + 3)) begin
        bad++; $display("FAIL dir_result[%0d] got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                        i, out_valid, result, tag_out, t_e[i], i + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 8 + STAGES; j++) begin
      if (j < 8) begin
        in_valid = 1'b1; op = 3'd0; a = 32'd1; b = XLEN'(j); tag = TAG_W'(j);
      end else idle_inputs();
      @(negedge clk);
      if (j < 8) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", j, in_ready); end
      end
      if (j >= STAGES) begin
        total++;
        if (out_valid !== 1'b1 || result !== (32'd1 << (j - STAGES)) || tag_out !== TAG_W'(j - STAGES)) begin
          bad++; $display("FAIL b2b_out[%0d] got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                          j - STAGES, out_valid, result, tag_out, 32'd1 << (j - STAGES), j - STAGES);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0]  held_r;
    logic [TAG_W-1:0] held_t;
    int n;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = 3'($urandom_range(0, 4)); a = $urandom; b = $urandom; tag = TAG_W'(c + 10);
      @(negedge clk);
      if (c == STAGES) begin held_r = result; held_t = tag_out; end
      if (c > STAGES) begin
        total++; if (result !== held_r || tag_out !== held_t || out_valid !== 1'b1) begin
          bad++; $display("FAIL bp_hold[%0d] got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                          c, out_valid, result, tag_out, held_r, held_t);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++; if (exp_q.size() != STAGES) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", exp_q.size(), STAGES); end
    @(posedge clk); #1 idle_inputs(); out_ready = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_drain_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i].res !== exp_q[i].res || got_q[i].tag !== exp_q[i].tag) begin
        bad++; $display("FAIL bp_drain[%0d] got r=%h t=%0d want r=%h t=%0d",
                        i, got_q[i].res, got_q[i].tag, exp_q[i].res, exp_q[i].tag);
      end
    end
  endtask

  task automatic test_flush();
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; op = 3'd1; a = $urandom; b = $urandom; tag = TAG_W'(20 + c);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; op = 3'd0; a = 32'h1234_5678; b = 32'd4; tag = TAG_W'(22); flush = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%b want=1", out_valid); end
    @(posedge clk); #1 idle_inputs(); out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid[%0d] got=%b want=0", c, out_valid); end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL flush_leak got=%0d results want=0", got_q.size()); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < STAGES; c++) begin
      in_valid = 1'b1; op = 3'd3; a = $urandom; b = $urandom; tag = TAG_W'(c);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b want=1", out_valid); end
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL arst_async got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_random();
    int n;
    exp_q.delete(); got_q.delete();
    @(posedge clk); #1;
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; tag = TAG_W'($urandom);
      @(posedge clk); #1;
    end
    idle_inputs(); out_ready = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 50) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i].res !== exp_q[i].res || got_q[i].tag !== exp_q[i].tag) begin
        bad++; $display("FAIL rand[%0d] got r=%h t=%0d want r=%h t=%0d",
                        i, got_q[i].res, got_q[i].tag, exp_q[i].res, exp_q[i].tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
